// File: rtl/phase_angle_calc.sv
// Phase angle readout: averages 2^AVG_LOG2 phase-difference counts, then
// converts the average to 0.1-degree units with a sequential restoring divider.
module phase_angle_calc #(
  parameter int CNT_W    = 32,
  parameter int AVG_LOG2 = 3,
  parameter int ANGLE_W  = 12
) (
  input  logic               sysClk,
  input  logic               sysRst,
  input  logic               diffValid,
  input  logic [CNT_W-1:0]   diffCount,
  input  logic               periodValid,
  input  logic [CNT_W-1:0]   periodCount,
  output logic               angleValid,
  output logic [ANGLE_W-1:0] angle,
  output logic               busy,
  output logic               zeroDivErr,
  output logic               ovfErr
);

  localparam int DW    = CNT_W + 12;
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int BC_W  = $clog2(DW);
  localparam logic [DW-1:0]      SCALE     = DW'(3600);
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(3599);

  typedef enum logic [1:0] {ACCUM, MULT, DIV, DONE} state_t;

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [CNT_W-1:0]    r_period;
  logic [CNT_W-1:0]    r_divisor;
  logic [DW-1:0]       r_quo;
  logic [CNT_W:0]      r_rem;
  logic [BC_W-1:0]     r_bitcnt;
  logic                r_zero;

  logic [CNT_W-1:0]    w_avg;
  logic [DW-1:0]       w_dividend;
  logic [CNT_W+1:0]    w_rem_sh;
  logic [CNT_W+1:0]    w_trial;
  logic                w_qbit;
  logic [CNT_W:0]      w_rem_next;

  assign w_avg      = r_acc[ACC_W-1:AVG_LOG2];
  assign w_dividend = DW'(w_avg) * SCALE;

  // Restoring step: bring in the next dividend bit, keep the subtraction only if it stays non-negative.
  assign w_rem_sh   = {r_rem, r_quo[DW-1]};
  assign w_trial    = w_rem_sh - {2'b00, r_divisor};
  assign w_qbit     = ~w_trial[CNT_W+1];
  assign w_rem_next = w_qbit ? w_trial[CNT_W:0] : w_rem_sh[CNT_W:0];

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      r_period <= '0;
    end else if (periodValid) begin
      r_period <= periodCount;
    end
  end

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      r_state    <= ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_bitcnt   <= '0;
      r_zero     <= 1'b0;
      angleValid <= 1'b0;
      angle      <= '0;
      busy       <= 1'b0;
      zeroDivErr <= 1'b0;
      ovfErr     <= 1'b0;
    end else begin
      angleValid <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (diffValid) begin
            r_acc <= r_acc + ACC_W'(diffCount);
            r_cnt <= r_cnt + AVG_LOG2'(1);
            if (r_cnt == '1) begin
              r_state <= MULT;
              busy    <= 1'b1;
            end
          end
        end
        MULT: begin
          r_quo     <= w_dividend;
          r_divisor <= r_period;
          r_rem     <= '0;
          r_bitcnt  <= '0;
          r_acc     <= '0;
          r_cnt     <= '0;
          if (r_period == '0) begin
            r_zero  <= 1'b1;
            r_state <= DONE;
            busy    <= 1'b0;
          end else begin
            r_zero  <= 1'b0;
            r_state <= DIV;
          end
        end
        DIV: begin
          r_quo    <= {r_quo[DW-2:0], w_qbit};
          r_rem    <= w_rem_next;
          r_bitcnt <= r_bitcnt + BC_W'(1);
          if (r_bitcnt == BC_W'(DW-1)) begin
            r_state <= DONE;
            busy    <= 1'b0;
          end
        end
        DONE: begin
          angleValid <= 1'b1;
          zeroDivErr <= r_zero;
          if (r_zero) begin
            angle  <= '0;
            ovfErr <= 1'b0;
          end else if (r_quo >= DW'(3600)) begin
            angle  <= ANGLE_MAX;
            ovfErr <= 1'b1;
          end else begin
            angle  <= r_quo[ANGLE_W-1:0];
            ovfErr <= 1'b0;
          end
          r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_angle_calc.sv
// Scoreboard bench for phase_angle_calc: a driver predicts each result from
// block averages and pushes it; a monitor pops and compares on angleValid.
module tb_phase_angle_calc;

  logic        sysClk = 1'b0;
  logic        sysRst;
  logic        diffValid;
  logic [31:0] diffCount;
  logic        periodValid;
  logic [31:0] periodCount;
  logic        angleValid;
  logic [11:0] angle;
  logic        busy;
  logic        zeroDivErr;
  logic        ovfErr;

  phase_angle_calc #(.CNT_W(32), .AVG_LOG2(3), .ANGLE_W(12)) dut (
    .sysClk(sysClk), .sysRst(sysRst),
    .diffValid(diffValid), .diffCount(diffCount),
    .periodValid(periodValid), .periodCount(periodCount),
    .angleValid(angleValid), .angle(angle), .busy(busy),
    .zeroDivErr(zeroDivErr), .ovfErr(ovfErr)
  );

  always #5 sysClk = ~sysClk;

  longint edge_cnt = 0;
  always @(posedge sysClk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    longint ang;
    longint zde;
    longint ovf;
    longint edge_at;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_err    = 0;

  longint m_period;
  longint m_sum;
  int     m_cnt;
  longint m_ready;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_period = 0;
    m_sum    = 0;
    m_cnt    = 0;
    m_ready  = 0;
  endtask

  // Result of one completed block, in plain arithmetic.
  task automatic predict(input longint e);
    exp_t   x;
    longint avg, q, lat;
    avg = m_sum / 8;
    if (m_period == 0) begin
      x.ang = 0; x.zde = 1; x.ovf = 0; lat = 2;
    end else begin
      q = (avg * 3600) / m_period;
      x.zde = 0;
      if (q >= 3600) begin x.ang = 3599; x.ovf = 1; end
      else begin x.ang = q; x.ovf = 0; end
      lat = 46;
    end
    x.edge_at = e + lat;
    m_ready   = e + lat + 1;
    exp_q.push_back(x);
  endtask

  // Called at a negedge; inputs are sampled by the next posedge.
  task automatic step(input bit dv, input logic [31:0] dc, input bit pv, input logic [31:0] pc);
    longint e;
    diffValid   = dv;
    diffCount   = dc;
    periodValid = pv;
    periodCount = pc;
    e = edge_cnt + 1;
    if (pv) m_period = pc;
    if (dv && e >= m_ready) begin
      m_sum += dc;
      m_cnt++;
      if (m_cnt == 8) begin
        predict(e);
        m_cnt = 0;
        m_sum = 0;
      end
    end
    @(negedge sysClk);
    diffValid   = 1'b0;
    periodValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && (edge_cnt + 1 < m_ready); i++) idle(1);
    idle(1);
  endtask

  task automatic block(input logic [31:0] d);
    for (int i = 0; i < 8; i++) step(1'b1, d, 1'b0, 32'd0);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge sysClk);
      if (angleValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_angleValid: got angle %0d, expected no output", angle);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("angle", longint'(angle), x.ang);
          check("zeroDivErr", longint'(zeroDivErr), x.zde);
          check("ovfErr", longint'(ovfErr), x.ovf);
          check("latency_edge", edge_cnt, x.edge_at);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sysRst = 1'b0; diffValid = 1'b0; diffCount = '0;
    periodValid = 1'b0; periodCount = '0;
    model_reset();
    repeat (3) @(negedge sysClk);
    check("rst_angle", longint'(angle), 0);
    check("rst_valid", longint'(angleValid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_flags", longint'({zeroDivErr, ovfErr}), 0);
    sysRst = 1'b1;
    @(negedge sysClk);

    // Zero period (nothing loaded since reset), then recovery
    block(32'd50);
    wait_ready();
    step(1'b0, 32'd0, 1'b1, 32'd400);
    block(32'd100);
    wait_ready();

    // Basic angle and output hold
    step(1'b0, 32'd0, 1'b1, 32'd1000);
    block(32'd250);
    wait_ready();
    idle(3);
    check("hold_angle", longint'(angle), 900);
    check("hold_flags", longint'({zeroDivErr, ovfErr}), 0);

    // Truncating average: 4x100 + 4x101
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2) ? 32'd101 : 32'd100, 1'b0, 32'd0);
    wait_ready();

    // Overflow clamp then clear
    block(32'd1200);
    wait_ready();
    block(32'd500);
    wait_ready();

    // Busy drop and period race
    block(32'd250);
    for (int i = 0; i < 5; i++) step(1'b1, 32'd999, 1'b0, 32'd0);
    check("busy_in_div", longint'(busy), 1);
    step(1'b0, 32'd0, 1'b1, 32'd500);
    check("busy_after_race", longint'(busy), 1);
    wait_ready();
    block(32'd250);
    wait_ready();

    // Simultaneous diffValid and periodValid on the final strobe
    for (int i = 0; i < 7; i++) step(1'b1, 32'd300, 1'b0, 32'd0);
    step(1'b1, 32'd300, 1'b1, 32'd2000);
    wait_ready();

    // Reset mid-DIV
    step(1'b0, 32'd0, 1'b1, 32'd1000);
    block(32'd250);
    idle(10);
    sysRst = 1'b0;
    #1;
    check("midrst_angle", longint'(angle), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_valid", longint'(angleValid), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge sysClk);
    sysRst = 1'b1;
    @(negedge sysClk);
    idle(50);
    check("post_rst_angle", longint'(angle), 0);
    step(1'b0, 32'd0, 1'b1, 32'd1000);
    block(32'd250);
    wait_ready();

    // Randomized traffic: strobes while busy, period updates anywhere, occasional zero period
    for (int blk = 0; blk < 12; blk++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      step(1'b0, 32'd0, 1'b1, p);
      for (int c = 0; c < 60; c++) begin
        logic [31:0] d;
        bit dv, pv;
        dv = ($urandom_range(0, 1) == 1);
        pv = ($urandom_range(0, 29) == 0);
        d  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20000));
        step(dv, d, pv, 32'($urandom_range(1, 4000)));
      end
    end
    wait_ready();

    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge sysClk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/phase_angle_calc.md
Name: phase_angle_calc

Overview:
- Downstream consumer of the phase-difference counter.
- Takes raw phase-difference counts (workClk ticks between CHA and CHB edges) and the matching signal-period count.
- Averages 2^AVG_LOG2 difference samples, then converts the average to a phase angle in 0.1-degree units: angle = avg*3600/period.
- Uses a sequential restoring divider. Result feeds the display/readout logic.

Parameters:
- CNT_W, 32, width of the diffCount and periodCount inputs.
- AVG_LOG2, 3, log2 of the number of difference samples averaged (default 8).
- ANGLE_W, 12, width of the angle output (holds 0..3599).

Ports:
- sysClk  input  1  system clock; the only clock.
- sysRst  input  1  asynchronous, active-low reset.
- diffValid  input  1  one-cycle strobe, synchronous to sysClk: diffCount holds a new sample.
- diffCount  input  CNT_W  phase-difference count.
- periodValid  input  1  one-cycle strobe: periodCount holds a new period.
- periodCount  input  CNT_W  signal period in the same tick units.
- angleValid  output  1  one-cycle strobe: angle updated.
- angle  output  ANGLE_W  phase in 0.1 degree units.
- busy  output  1  high while in MULT or DIV.
- zeroDivErr  output  1  sticky: last computation had period==0.
- ovfErr  output  1  sticky: last computation had result >=3600 (clamped).

Behaviour:
- Reset (sysRst low, asynchronous): clear all outputs, the accumulator, the sample counter and the period register; state=ACCUM.
- Period register:
  - Loaded with periodCount on every periodValid, in any state.
  - The divisor is a separate copy, latched in MULT. A period update during DIV does not affect the current result.
- ACCUM:
  - On diffValid: acc += diffCount. acc is CNT_W+AVG_LOG2 bits and cannot overflow.
  - Sample counter increments on each diffValid.
  - On the diffValid that brings the count to 2^AVG_LOG2: go to MULT.
- MULT (1 cycle):
  - avg = acc >> AVG_LOG2 (truncate).
  - dividend = avg*3600, CNT_W+12 bits.
  - Latch divisor = period register.
  - Clear acc and the sample counter.
  - If divisor==0: skip DIV, go to DONE with angle forced to 0, zeroDivErr=1. Otherwise go to DIV.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Exactly CNT_W+12 cycles, then go to DONE.
- DONE (1 cycle):
  - If quotient >=3600: angle=3599, ovfErr=1. Otherwise angle=quotient[ANGLE_W-1:0], ovfErr=0.
  - zeroDivErr updated for this computation (set on divide-by-zero, cleared otherwise).
  - angleValid=1 for exactly this cycle, then back to ACCUM.
- Output hold: angle, zeroDivErr and ovfErr hold their values until the next DONE.
- Latency: angleValid is high in the cycle after the (CNT_W+14)th sysClk edge counted from the edge that samples the final diffValid. That is 46 edges at the default. With divisor==0 the latency is 2 edges.
- Samples arriving while busy:
  - diffValid during MULT, DIV or DONE is ignored; the sample is discarded.
  - Accumulation restarts from zero on re-entering ACCUM.
- Simultaneous diffValid and periodValid: both captured in the same cycle. The new period is used by the computation that this diffValid triggers, because MULT reads the period register one edge later.
- busy = (state==MULT or state==DIV).
- Reset mid-operation (asserted during DIV): the computation is aborted. No angleValid. Outputs read 0 on release.

Test Plan:
- Basic angle: periodValid with periodCount=1000, then 8 diffValid with diffCount=250 → one angleValid, angle=900, latency 46 edges after the 8th strobe, both error flags 0.
- Averaging truncation: period 1000; diffCount alternating 100,101 ×4 each (sum 804, avg 100) → angle=360.
- Zero period: no periodValid after reset; 8 samples of 50 → angle=0, zeroDivErr=1, angleValid 2 edges after the 8th strobe. Then period 400 and 8×100 → angle=900, zeroDivErr=0.
- Overflow clamp: period 1000; 8×1200 → angle=3599, ovfErr=1. Next block of 8×500 → angle=1800, ovfErr=0.
- Busy drop and period race:
  - 8 strobes at 250 with period 1000, then 5 extra strobes at 999 while busy → result 900.
  - periodValid with periodCount=500 during DIV → still 900.
  - The next 8×250 → 1800.
- Reset mid-DIV: pull sysRst low 10 cycles into DIV → no angleValid; angle=0, busy=0 immediately. After release, 8×250 at period 1000 → angle=900.
